// File: rtl/eval_dispatch_pkg.sv
// Shared types for the evaluator dispatcher: FSM states, default widths, request record.
// BOARD_WIDTH normally arrives from the chess header; the fallback keeps this slice self-contained.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

package eval_dispatch_pkg;

   localparam int BOARD_W        = `BOARD_WIDTH;
   localparam int EVAL_WIDTH_DEF = 22;
   localparam int TAG_WIDTH_DEF  = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ISSUE,
      ST_RETIRE,
      ST_GAP
`ifdef EVAL_DISPATCH_WATCHDOG_EN
      , ST_HALT
`endif
   } state_e;

   typedef struct packed {
      logic [BOARD_W-1:0]       board;
      logic                     white_to_move;
      logic [TAG_WIDTH_DEF-1:0] tag;
   } req_t;

endpackage

// File: rtl/eval_dispatch_fifo.sv
// First-word fall-through request FIFO, 2^DEPTH_LOG2 entries.
// A push while full is accepted only when a pop happens in the same cycle.
module eval_dispatch_fifo
   import eval_dispatch_pkg::*;
#(
   parameter int  DEPTH_LOG2 = 2,
   parameter type T          = req_t
) (
   input  logic clk,
   input  logic reset,
   input  logic push,
   input  T     wdata,
   input  logic pop,
   output T     rdata,
   output logic full,
   output logic empty
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   T                      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
   logic                  do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == (DEPTH_LOG2+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_push && !do_pop)
         cnt_d = cnt_q + 1'b1;
      else if (do_pop && !do_push)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push)
         mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/eval_dispatch.sv
// Evaluator initiator: queues tagged boards, sequences board_valid/clear_eval, returns tagged scores.
// EVAL_DISPATCH_WATCHDOG_EN adds an ISSUE timeout that parks the FSM in HALT and raises watchdog_err.
module eval_dispatch
   import eval_dispatch_pkg::*;
#(
   parameter int EVAL_WIDTH      = EVAL_WIDTH_DEF,
   parameter int TAG_WIDTH       = TAG_WIDTH_DEF,
   parameter int FIFO_DEPTH_LOG2 = 2,
   parameter int TIMEOUT_CYCLES  = 4096
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [BOARD_W-1:0]           req_board,
   input  logic                         req_white_to_move,
   input  logic [TAG_WIDTH-1:0]         req_tag,
   input  logic                         req_valid,
   output logic                         req_ready,
   output logic [BOARD_W-1:0]           board_out,
   output logic                         white_to_move,
   output logic                         board_valid,
   output logic                         clear_eval,
   input  logic signed [EVAL_WIDTH-1:0] eval,
   input  logic                         eval_valid,
   input  logic                         insufficient_material,
   output logic signed [EVAL_WIDTH-1:0] res_eval,
   output logic                         res_insufficient,
   output logic [TAG_WIDTH-1:0]         res_tag,
   output logic                         res_valid,
   input  logic                         res_ready,
   output logic                         busy,
   output logic [31:0]                  eval_count
`ifdef EVAL_DISPATCH_WATCHDOG_EN
  ,output logic                         watchdog_err
`endif
);

   state_e state_q, state_d;

   req_t fifo_wdata, fifo_rdata;
   logic fifo_full, fifo_empty, fifo_push, fifo_pop, capture, wd_expire;

   logic [BOARD_W-1:0]           board_q, board_d;
   logic                         wtm_q, wtm_d;
   logic [TAG_WIDTH-1:0]         tag_q, tag_d;
   logic signed [EVAL_WIDTH-1:0] res_eval_q, res_eval_d;
   logic                         res_ins_q, res_ins_d;
   logic [TAG_WIDTH-1:0]         res_tag_q, res_tag_d;
   logic                         res_valid_q, res_valid_d;
   logic [31:0]                  count_q, count_d;

   assign fifo_wdata = '{board: req_board, white_to_move: req_white_to_move, tag: req_tag};
   assign fifo_push  = req_valid && req_ready;
   // A result still waiting at the port blocks the next pop, even if it is accepted this cycle.
   assign fifo_pop   = (state_q == ST_IDLE) && !fifo_empty && !res_valid_q;
   assign capture    = (state_q == ST_ISSUE) && eval_valid;

   eval_dispatch_fifo #(
      .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
      .T          (req_t)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (fifo_wdata),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

`ifdef EVAL_DISPATCH_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
   logic            wd_err_q, wd_err_d;

   assign wd_expire    = (state_q == ST_ISSUE) && !eval_valid && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
   assign wd_cnt_d     = (state_q == ST_ISSUE) ? wd_cnt_q + 1'b1 : '0;
   assign wd_err_d     = wd_err_q || wd_expire;
   assign watchdog_err = wd_err_q;
   assign req_ready    = !fifo_full && (state_q != ST_HALT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wd_cnt_q <= '0;
         wd_err_q <= 1'b0;
      end else begin
         wd_cnt_q <= wd_cnt_d;
         wd_err_q <= wd_err_d;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign req_ready = !fifo_full;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (fifo_pop) state_d = ST_SETUP;
         ST_SETUP:  state_d = ST_ISSUE;
         ST_ISSUE: begin
            if (eval_valid)
               state_d = ST_RETIRE;
`ifdef EVAL_DISPATCH_WATCHDOG_EN
            else if (wd_expire)
               state_d = ST_HALT;
`endif
         end
         ST_RETIRE: state_d = ST_GAP;
         ST_GAP:    state_d = ST_IDLE;
         default:   state_d = state_q;
      endcase
   end

   always_comb begin
      board_valid = (state_q == ST_ISSUE);
      clear_eval  = (state_q == ST_RETIRE);
      busy        = !fifo_empty || (state_q != ST_IDLE);
   end

   always_comb begin
      board_d     = board_q;
      wtm_d       = wtm_q;
      tag_d       = tag_q;
      res_eval_d  = res_eval_q;
      res_ins_d   = res_ins_q;
      res_tag_d   = res_tag_q;
      res_valid_d = res_valid_q;
      count_d     = count_q;
      if (fifo_pop) begin
         board_d = fifo_rdata.board;
         wtm_d   = fifo_rdata.white_to_move;
         tag_d   = fifo_rdata.tag;
      end
      if (capture) begin
         res_eval_d  = eval;
         res_ins_d   = insufficient_material;
         res_tag_d   = tag_q;
         res_valid_d = 1'b1;
      end else if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
      if (state_q == ST_RETIRE)
         count_d = count_q + 32'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         board_q     <= '0;
         wtm_q       <= 1'b0;
         tag_q       <= '0;
         res_eval_q  <= '0;
         res_ins_q   <= 1'b0;
         res_tag_q   <= '0;
         res_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         board_q     <= board_d;
         wtm_q       <= wtm_d;
         tag_q       <= tag_d;
         res_eval_q  <= res_eval_d;
         res_ins_q   <= res_ins_d;
         res_tag_q   <= res_tag_d;
         res_valid_q <= res_valid_d;
         count_q     <= count_d;
      end
   end

   assign board_out        = board_q;
   assign white_to_move    = wtm_q;
   assign res_eval         = res_eval_q;
   assign res_insufficient = res_ins_q;
   assign res_tag          = res_tag_q;
   assign res_valid        = res_valid_q;
   assign eval_count       = count_q;

endmodule
